mux_n_1_stream: RTL and testbench
=================================

Name: mux_n_1_stream

Overview:
- Parametrised successor of the team's 4:1 combinational multiplexer.
- Selects one of N valid/ready input channels onto a single registered output channel.
- Selection is either fixed (external select) or round-robin arbitration.
- Sits between multiple producers and one shared consumer, e.g. sensor or UART sources feeding one sink.

Parameters:
- N, 4, number of input channels (2..16)
- W, 8, data width per channel
- MODE, 0, 0 = fixed select from sel port, 1 = round-robin arbitration (sel ignored)
- SW, $clog2(N), select/channel-index width (derived, do not override)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_valid  in  N  per-channel valid
- in_last  in  N  per-channel end-of-packet flag; used only with the optional feature
- in_ready  out  N  per-channel ready; one-hot or zero
- sel  in  SW  channel select when MODE=0
- out_data  out  W  registered data
- out_ch  out  SW  index of the channel that supplied out_data
- out_last  out  1  registered copy of in_last of the granted beat
- out_valid  out  1  output holds a beat
- out_ready  in  1  consumer accepts the beat

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_ch=0, out_last=0.
  - Round-robin pointer last_grant=N-1, so channel 0 has first priority.
- Single output register, one beat deep. load = !out_valid || out_ready.
- Grant:
  - MODE=0: grant=sel if in_valid[sel], else none. sel >= N means no grant.
  - MODE=1: first valid channel searching from last_grant+1 upward with wrap-around (N-1 -> 0).
- in_ready[i] = load && grant_valid && grant==i. in_ready is combinational from in_valid, sel, out_valid and out_ready; no combinational path from in_data.
- Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge:
  - out_data/out_ch/out_last take that channel's values; out_valid=1.
  - In MODE=1, last_grant=i.
- If load and no grant: out_valid goes to 0 on the next edge; out_data, out_ch and out_last hold their values.
- Latency: 1 cycle input-to-output. Full throughput of 1 beat per cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, all in_ready=0 and the output is stable, data unchanged.
- Simultaneous pop and push in the same cycle: new beat replaces the old one with no bubble.
- MODE=1 fairness: a continuously valid channel waits at most N-1 grants.
- Reset mid-transfer discards the held beat; inputs see in_ready=0 while rst_n=0.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN
- Defined:
  - After a granted beat with in_last=0, the grant locks to that channel until a beat with in_last=1 transfers.
  - While locked, other channels get in_ready=0 even when the locked channel is not valid.
  - sel changes are ignored while locked, in both modes.
  - A lock flag register resets to 0.
- Not defined:
  - in_last is only passed through to out_last; arbitration is per beat.
  - The lock register is not instantiated.

Decomposition:
- Package mux_pkg:
  - mode constants MUX_MODE_FIXED=0, MUX_MODE_RR=1
  - a function computing the next round-robin index with wrap
- Sub-module rr_arbiter (N, req[N] -> gnt_idx, gnt_valid, with last_grant input):
  - combinational priority rotation
  - instantiated only when MODE=1

Test Plan:
- Reset: assert rst_n=0 mid-traffic -> out_valid=0, out_data=0, in_ready=0 immediately, asynchronously.
- MODE=0, N=4, W=8: sel=2, in_valid=4'b0100, data2=8'hA5, out_ready=1 -> next cycle out_data=8'hA5, out_ch=2, out_valid=1; sel=3 with in_valid[3]=0 -> no in_ready, out_valid drops.
- MODE=1: in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 with one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0; release -> next beat loads in the same cycle as the pop.
- MODE=1 wrap: last_grant=3, in_valid=4'b0110 -> grant 1, then 2, then 1.
- With MUX_PKT_LOCK_EN: channel 1 sends 3 beats with in_last=0,0,1 while channel 2 is valid -> out_ch=1,1,1 then 2; without the macro -> interleaved 1,2,1,2.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 valid/ready stream multiplexer.
package mux_pkg;

    localparam int MUX_MODE_FIXED = 0;
    localparam int MUX_MODE_RR    = 1;

    // Next channel index after idx, wrapping N-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching upward from
// last_grant+1 with wrap-around.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last_grant,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_valid
);

    int            idx;
    logic [SW-1:0] pos;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        pos       = '0;
        idx       = int'(last_grant);
        for (int k = 0; k < N; k++) begin
            idx = rr_next(idx, N);
            pos = SW'(idx);
            if (!gnt_valid && req[pos]) begin
                gnt_valid = 1'b1;
                gnt_idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// N:1 valid/ready stream multiplexer with a one-beat registered output.
// Optional packet locking is enabled by defining MUX_PKT_LOCK_EN.
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MUX_MODE_FIXED,
    parameter int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_last,
    output logic           out_valid,
    input  logic           out_ready
);

    logic          load;
    logic          xfer;
    logic          base_valid;
    logic [SW-1:0] base_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;

    logic          vld_p1;
    logic [W-1:0]  data_p1;
    logic [SW-1:0] ch_p1;
    logic          last_p1;

    assign load = !vld_p1 || out_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SW-1:0] last_grant;

            rr_arbiter #(.N(N), .SW(SW)) u_arb (
                .req        (in_valid),
                .last_grant (last_grant),
                .gnt_idx    (base_idx),
                .gnt_valid  (base_valid)
            );

            // Reset to N-1 so channel 0 wins the first arbitration.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    last_grant <= SW'(N - 1);
                else if (xfer)
                    last_grant <= grant_idx;
            end
        end else begin : g_fixed
            // Compare against each index so sel >= N simply yields no grant.
            always_comb begin
                base_idx   = sel;
                base_valid = 1'b0;
                for (int i = 0; i < N; i++)
                    if (int'(sel) == i && in_valid[i])
                        base_valid = 1'b1;
            end
        end
    endgenerate

`ifdef MUX_PKT_LOCK_EN
    logic          lock_q;
    logic [SW-1:0] lock_ch;

    // A locked channel owns the output even while it is idle.
    always_comb begin
        if (lock_q) begin
            grant_idx   = lock_ch;
            grant_valid = in_valid[lock_ch];
        end else begin
            grant_idx   = base_idx;
            grant_valid = base_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            lock_q  <= !in_last[grant_idx];
            lock_ch <= grant_idx;
        end
    end
`else
    assign grant_idx   = base_idx;
    assign grant_valid = base_valid;
`endif

    // rst_n gating keeps every in_ready low while reset is held.
    assign xfer     = rst_n && load && grant_valid;
    assign in_ready = xfer ? (N'(1) << grant_idx) : '0;

    // Output stage: one beat deep, refilled whenever it is empty or popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            last_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= in_data[grant_idx*W +: W];
                ch_p1   <= grant_idx;
                last_p1 <= in_last[grant_idx];
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign out_last  = last_p1;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Self-checking bench for mux_n_1_stream: fixed-select and round-robin
// instances side by side, directed scenarios plus a randomized model run.
module tb_mux_n_1_stream;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [1:0]     sel;
    logic           out_ready;

    logic [N-1:0] fx_ready, rr_ready;
    logic [W-1:0] fx_data, rr_data;
    logic [1:0]   fx_ch, rr_ch;
    logic         fx_last, rr_last, fx_valid, rr_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_n_1_stream #(.N(N), .W(W), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(fx_ready), .sel(sel),
        .out_data(fx_data), .out_ch(fx_ch), .out_last(fx_last),
        .out_valid(fx_valid), .out_ready(out_ready)
    );

    mux_n_1_stream #(.N(N), .W(W), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rr_ready), .sel(sel),
        .out_data(rr_data), .out_ch(rr_ch), .out_last(rr_last),
        .out_valid(rr_valid), .out_ready(out_ready)
    );

    // Reference model, index 0 = fixed select, 1 = round robin.
    logic         m_vld[2];
    logic [W-1:0] m_data[2];
    int           m_ch[2];
    logic         m_last[2];
    int           m_lg[2];
    logic         m_lock[2];
    int           m_lch[2];

    function automatic int exp_grant(input int m);
        int c;
`ifdef MUX_PKT_LOCK_EN
        if (m_lock[m]) return in_valid[m_lch[m]] ? m_lch[m] : -1;
`endif
        if (m == 0) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_lg[m] + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        int g;
        g = exp_grant(m);
        if (!rst_n || g < 0 || (m_vld[m] && !out_ready)) return '0;
        return 4'(1) << g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_vld[m] <= 1'b0; m_data[m] <= '0; m_ch[m] <= 0; m_last[m] <= 1'b0;
                m_lg[m] <= N - 1; m_lock[m] <= 1'b0; m_lch[m] <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                g = exp_grant(m);
                if (!m_vld[m] || out_ready) begin
                    if (g >= 0) begin
                        m_vld[m]  <= 1'b1;
                        m_data[m] <= in_data[g*W +: W];
                        m_ch[m]   <= g;
                        m_last[m] <= in_last[g];
                        if (m == 1) m_lg[m] <= g;
                        m_lock[m] <= !in_last[g];
                        m_lch[m]  <= g;
                    end else begin
                        m_vld[m] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1; sel = 2'd0;
        in_data = 32'hDEAD_BEEF;
        tick(); tick(); tick();
        #2;
        checks++;
        if (fx_valid !== 1'b1) begin
            failures++; $display("FAIL reset_pre_traffic got=%b exp=1", fx_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fx_valid, fx_data, fx_ready} !== {1'b0, 8'h00, 4'b0000}) begin
            failures++;
            $display("FAIL reset_fix_async got=%b/%h/%b exp=0/00/0000", fx_valid, fx_data, fx_ready);
        end
        checks++;
        if ({rr_valid, rr_data, rr_ch, rr_last, rr_ready} !== {1'b0, 8'h00, 2'd0, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL reset_rr_async got=%b/%h/%0d/%b/%b exp=0/00/0/0/0000",
                     rr_valid, rr_data, rr_ch, rr_last, rr_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rr_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_rr_first_prio got=%b exp=0001", rr_ready);
        end
        checks++;
        if (fx_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_fix_ready got=%b exp=0001", fx_ready);
        end
        tick();
    endtask

    task automatic test_fixed_select();
        apply_reset();
        in_last = 4'b1111; out_ready = 1'b1; sel = 2'd2;
        in_valid = 4'b0100; in_data = 32'h00A5_0000;
        @(negedge clk);
        checks++;
        if (fx_ready !== 4'b0100) begin
            failures++; $display("FAIL fixed_ready got=%b exp=0100", fx_ready);
        end
        tick();
        sel = 2'd3;
        @(negedge clk);
        checks++;
        if ({fx_valid, fx_data, fx_ch} !== {1'b1, 8'hA5, 2'd2}) begin
            failures++;
            $display("FAIL fixed_out got=%b/%h/%0d exp=1/a5/2", fx_valid, fx_data, fx_ch);
        end
        checks++;
        if (fx_ready !== 4'b0000) begin
            failures++; $display("FAIL fixed_sel_invalid_ready got=%b exp=0000", fx_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({fx_valid, fx_data} !== {1'b0, 8'hA5}) begin
            failures++; $display("FAIL fixed_drop got=%b/%h exp=0/a5", fx_valid, fx_data);
        end
    endtask

    task automatic test_rr_sequence();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        in_last = 4'b1111; out_ready = 1'b1; sel = 2'd0;
        in_data = 32'h4433_2211; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({rr_valid, rr_ch, rr_data} !== {1'b1, 2'(seq[i]), 8'((seq[i] + 1) * 17)}) begin
                failures++;
                $display("FAIL rr_seq[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, rr_valid, rr_ch,
                         rr_data, seq[i], 8'((seq[i] + 1) * 17));
            end
            checks++;
            if (rr_ready !== 4'(1) << seq[i+1]) begin
                failures++; $display("FAIL rr_seq_ready[%0d] got=%b exp_ch=%0d", i, rr_ready, seq[i+1]);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_last = 4'b1111; out_ready = 1'b1; sel = 2'd1;
        in_valid = 4'b0010; in_data = 32'h0000_5A00;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = {16'h0000, 8'(8'h60 + i), 8'h00};
            @(negedge clk);
            checks++;
            if ({fx_valid, fx_data, fx_ready} !== {1'b1, 8'h5A, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/5a/0000", i, fx_valid, fx_data, fx_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        in_data = 32'h0000_C300;
        @(negedge clk);
        checks++;
        if (fx_ready !== 4'b0010) begin
            failures++; $display("FAIL bp_pop_push_ready got=%b exp=0010", fx_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({fx_valid, fx_data} !== {1'b1, 8'hC3}) begin
            failures++; $display("FAIL bp_release got=%b/%h exp=1/c3", fx_valid, fx_data);
        end
    endtask

    task automatic test_rr_wrap();
        int exp_ch[3] = '{1, 2, 1};
        apply_reset();
        in_last = 4'b1111; out_ready = 1'b1; sel = 2'd0;
        in_data = 32'h4433_2211; in_valid = 4'b1000;
        tick();
        in_valid = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({rr_valid, rr_ch} !== {1'b1, 2'(exp_ch[i])}) begin
                failures++;
                $display("FAIL rr_wrap[%0d] got=%b/%0d exp=1/%0d", i, rr_valid, rr_ch, exp_ch[i]);
            end
        end
    endtask

    task automatic test_packet();
`ifdef MUX_PKT_LOCK_EN
        int seq[4] = '{1, 1, 1, 2};
`else
        int seq[4] = '{1, 2, 1, 2};
`endif
        int beats1 = 0;
        apply_reset();
        out_ready = 1'b1; sel = 2'd0;
        in_data = 32'h4433_2211; in_valid = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            in_last = {2'b11, (beats1 % 3 == 2), 1'b1};
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (rr_ch !== 2'(seq[i-1])) begin
                    failures++; $display("FAIL pkt[%0d] got=%0d exp=%0d", i - 1, rr_ch, seq[i-1]);
                end
            end
            if (rr_ready[1]) beats1++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (fx_ready !== exp_ready(0)) begin
                failures++; $display("FAIL rand_fx_ready cyc=%0d got=%b exp=%b", cyc, fx_ready, exp_ready(0));
            end
            checks++;
            if (rr_ready !== exp_ready(1)) begin
                failures++; $display("FAIL rand_rr_ready cyc=%0d got=%b exp=%b", cyc, rr_ready, exp_ready(1));
            end
            checks++;
            if (fx_valid !== m_vld[0] || (m_vld[0] &&
                {fx_data, fx_ch, fx_last} !== {m_data[0], 2'(m_ch[0]), m_last[0]})) begin
                failures++;
                $display("FAIL rand_fx_out cyc=%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", cyc, fx_valid,
                         fx_data, fx_ch, fx_last, m_vld[0], m_data[0], m_ch[0], m_last[0]);
            end
            checks++;
            if (rr_valid !== m_vld[1] || (m_vld[1] &&
                {rr_data, rr_ch, rr_last} !== {m_data[1], 2'(m_ch[1]), m_last[1]})) begin
                failures++;
                $display("FAIL rand_rr_out cyc=%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", cyc, rr_valid,
                         rr_data, rr_ch, rr_last, m_vld[1], m_data[1], m_ch[1], m_last[1]);
            end
            tick();
        end
    endtask

    initial begin
        in_data = '0; in_valid = '0; in_last = '0; sel = '0; out_ready = 1'b0;
        apply_reset();
        test_reset();
        test_fixed_select();
        test_rr_sequence();
        test_backpressure();
        test_rr_wrap();
        test_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
